// File: rtl/pixel_arbiter_if.sv
// Pixel source / framebuffer write bundle between the scanner, draw logic and pixel_arbiter.
// The arbiter uses the slave modport; master is the environment side.
interface pixel_arbiter_if #(
    parameter int unsigned COLOR_W = 1
);
    logic               clr_en;
    logic [9:0]         clr_x;
    logic [8:0]         clr_y;
    logic               clr_done;
    logic               drw_valid;
    logic [9:0]         drw_x;
    logic [8:0]         drw_y;
    logic [COLOR_W-1:0] drw_color;
    logic               drw_ready;
    logic               plot;
    logic [9:0]         px_x;
    logic [8:0]         px_y;
    logic [COLOR_W-1:0] px_color;
    logic               busy_clear;
    logic               frame_cleared;
    logic [15:0]        drop_count;

    modport master (
        output clr_en, clr_x, clr_y, clr_done, drw_valid, drw_x, drw_y, drw_color,
        input  drw_ready, plot, px_x, px_y, px_color, busy_clear, frame_cleared, drop_count
    );

    modport slave (
        input  clr_en, clr_x, clr_y, clr_done, drw_valid, drw_x, drw_y, drw_color,
        output drw_ready, plot, px_x, px_y, px_color, busy_clear, frame_cleared, drop_count
    );
endinterface

// File: rtl/pixel_arbiter.sv
// Selects the clear scanner or a draw request each cycle, clips off-screen samples
// and issues a registered framebuffer write; pulses frame_cleared per completed clear.
module pixel_arbiter #(
    parameter int unsigned WIDTH       = 640,
    parameter int unsigned HEIGHT      = 480,
    parameter int unsigned COLOR_W     = 1,
    parameter int unsigned CLEAR_COLOR = 0
) (
    input logic            clk,
    input logic            reset,
    pixel_arbiter_if.slave bus
);
    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 9;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               plot_q, plot_d;
    logic [X_W-1:0]     px_x_q, px_x_d;
    logic [Y_W-1:0]     px_y_q, px_y_d;
    logic [COLOR_W-1:0] px_color_q, px_color_d;
    logic               busy_clear_q, busy_clear_d;
    logic               frame_cleared_q, frame_cleared_d;
    logic [CNT_W-1:0]   drop_count_q, drop_count_d;

    logic               start_c;
    logic               take_c;
    logic               in_range_c;
    logic [X_W-1:0]     smp_x_c;
    logic [Y_W-1:0]     smp_y_c;
    logic [COLOR_W-1:0] smp_color_c;

    // A pending clear start always beats a draw request.
    assign start_c       = bus.clr_en & ~bus.clr_done;
    assign bus.drw_ready = (state_q == IDLE) & ~start_c;

    // Next state and sample source selection.
    always_comb begin
        state_d     = state_q;
        take_c      = 1'b0;
        smp_x_c     = bus.drw_x;
        smp_y_c     = bus.drw_y;
        smp_color_c = bus.drw_color;
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d = CLEAR;
                end else begin
                    take_c = bus.drw_valid;
                end
            end
            CLEAR: begin
                // The done cycle and the abort cycle still carry a scanner sample.
                take_c      = 1'b1;
                smp_x_c     = bus.clr_x;
                smp_y_c     = bus.clr_y;
                smp_color_c = COLOR_W'(CLEAR_COLOR);
                if (bus.clr_done) begin
                    state_d = DONE;
                end else if (!bus.clr_en) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Clipping, write datapath and saturating drop counter.
    always_comb begin
        in_range_c      = (32'(smp_x_c) < WIDTH) && (32'(smp_y_c) < HEIGHT);
        plot_d          = take_c & in_range_c;
        px_x_d          = px_x_q;
        px_y_d          = px_y_q;
        px_color_d      = px_color_q;
        drop_count_d    = drop_count_q;
        busy_clear_d    = (state_d == CLEAR);
        frame_cleared_d = (state_d == DONE);
        if (plot_d) begin
            px_x_d     = smp_x_c;
            px_y_d     = smp_y_c;
            px_color_d = smp_color_c;
        end
        if (take_c && !in_range_c && (drop_count_q != CNT_MAX)) begin
            drop_count_d = drop_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            plot_q          <= 1'b0;
            px_x_q          <= '0;
            px_y_q          <= '0;
            px_color_q      <= '0;
            busy_clear_q    <= 1'b0;
            frame_cleared_q <= 1'b0;
            drop_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            plot_q          <= plot_d;
            px_x_q          <= px_x_d;
            px_y_q          <= px_y_d;
            px_color_q      <= px_color_d;
            busy_clear_q    <= busy_clear_d;
            frame_cleared_q <= frame_cleared_d;
            drop_count_q    <= drop_count_d;
        end
    end

    assign bus.plot          = plot_q;
    assign bus.px_x          = px_x_q;
    assign bus.px_y          = px_y_q;
    assign bus.px_color      = px_color_q;
    assign bus.busy_clear    = busy_clear_q;
    assign bus.frame_cleared = frame_cleared_q;
    assign bus.drop_count    = drop_count_q;
endmodule

// File: tb/tb_pixel_arbiter.sv
// Self-checking bench for pixel_arbiter: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the arbitration/clipping rules.
module tb_pixel_arbiter;
    localparam int unsigned COLOR_W = 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pixel_arbiter_if #(.COLOR_W(COLOR_W)) bus ();

    pixel_arbiter #(
        .WIDTH      (640),
        .HEIGHT     (480),
        .COLOR_W    (COLOR_W),
        .CLEAR_COLOR(0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase of the clear protocol plus the last write.
    typedef enum int {P_IDLE, P_CLEAR, P_DONE} phase_e;
    phase_e  m_phase = P_IDLE;
    bit      m_ready, m_plot, m_busy, m_frame;
    int      m_x, m_y, m_c;
    longint  m_drops;
    logic    obs_ready;

    function automatic bit on_screen(int x, int y);
        return (x < 640) && (y < 480);
    endfunction

    function automatic logic [15:0] exp_drops();
        return (m_drops > 65535) ? 16'hFFFF : 16'(m_drops);
    endfunction

    // Advance one clock: sample drw_ready before the edge, update the model, settle after.
    task automatic tick();
        bit start;
        bit take;
        int sx, sy, sc;
        #1;
        obs_ready = bus.drw_ready;
        start     = bus.clr_en && !bus.clr_done;
        m_ready   = (m_phase == P_IDLE) && !start;
        take = 1'b0; sx = 0; sy = 0; sc = 0;
        if (reset) begin
            m_phase = P_IDLE; m_plot = 1'b0;
            m_x = 0; m_y = 0; m_c = 0; m_drops = 0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (start) m_phase = P_CLEAR;
                    else if (bus.drw_valid) begin
                        take = 1'b1; sx = bus.drw_x; sy = bus.drw_y; sc = bus.drw_color;
                    end
                end
                P_CLEAR: begin
                    take = 1'b1; sx = bus.clr_x; sy = bus.clr_y; sc = 0;
                    if (bus.clr_done) m_phase = P_DONE;
                    else if (!bus.clr_en) m_phase = P_IDLE;
                end
                default: m_phase = P_IDLE;
            endcase
            m_plot = take && on_screen(sx, sy);
            if (m_plot) begin m_x = sx; m_y = sy; m_c = sc; end
            if (take && !on_screen(sx, sy)) m_drops++;
        end
        m_busy  = (m_phase == P_CLEAR);
        m_frame = (m_phase == P_DONE);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.clr_en = 1'b0; bus.clr_x = '0; bus.clr_y = '0; bus.clr_done = 1'b0;
        bus.drw_valid = 1'b0; bus.drw_x = '0; bus.drw_y = '0; bus.drw_color = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.plot !== 1'b0) begin errors++; $display("FAIL reset_plot got %0h exp 0", bus.plot); end
        checks++; if (bus.px_x !== 10'd0) begin errors++; $display("FAIL reset_px_x got %0d exp 0", bus.px_x); end
        checks++; if (bus.px_y !== 9'd0) begin errors++; $display("FAIL reset_px_y got %0d exp 0", bus.px_y); end
        checks++; if (bus.px_color !== 1'b0) begin errors++; $display("FAIL reset_px_color got %0h exp 0", bus.px_color); end
        checks++; if (bus.busy_clear !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", bus.busy_clear); end
        checks++; if (bus.frame_cleared !== 1'b0) begin errors++; $display("FAIL reset_frame got %0h exp 0", bus.frame_cleared); end
        checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", bus.drop_count); end
        #1;
        checks++; if (bus.drw_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h exp 1", bus.drw_ready); end
        // clr_en with clr_done already high must not start a clear
        bus.clr_en = 1'b1; bus.clr_done = 1'b1;
        tick(); tick();
        checks++; if (bus.busy_clear !== 1'b0) begin errors++; $display("FAIL en_and_done_no_start got %0h exp 0", bus.busy_clear); end
        drive_idle();
    endtask

    task automatic test_draw_in_range();
        do_reset();
        bus.drw_valid = 1'b1; bus.drw_x = 10'd5; bus.drw_y = 9'd7; bus.drw_color = 1'b1;
        tick();
        bus.drw_valid = 1'b0;
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL draw_ready got %0h exp 1", obs_ready); end
        checks++; if (bus.plot !== 1'b1) begin errors++; $display("FAIL draw_plot got %0h exp 1", bus.plot); end
        checks++; if (bus.px_x !== 10'd5 || bus.px_y !== 9'd7 || bus.px_color !== 1'b1) begin
            errors++; $display("FAIL draw_pixel got (%0d,%0d,%0d) exp (5,7,1)", bus.px_x, bus.px_y, bus.px_color);
        end
        tick();
        checks++; if (bus.plot !== 1'b0) begin errors++; $display("FAIL draw_plot_drop got %0h exp 0", bus.plot); end
        checks++; if (bus.px_x !== 10'd5 || bus.px_y !== 9'd7) begin
            errors++; $display("FAIL draw_hold got (%0d,%0d) exp (5,7)", bus.px_x, bus.px_y);
        end
    endtask

    task automatic test_clipping();
        int xs [3] = '{640, 639, 0};
        int ys [3] = '{10, 479, 480};
        bit exp_plot [3] = '{1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.drw_valid = 1'b1; bus.drw_x = 10'(xs[i]); bus.drw_y = 9'(ys[i]); bus.drw_color = 1'b1;
            tick();
            checks++; if (bus.plot !== exp_plot[i]) begin
                errors++; $display("FAIL clip_plot_%0d got %0h exp %0h", i, bus.plot, exp_plot[i]);
            end
        end
        bus.drw_valid = 1'b0;
        checks++; if (bus.px_x !== 10'd639 || bus.px_y !== 9'd479) begin
            errors++; $display("FAIL clip_last_pixel got (%0d,%0d) exp (639,479)", bus.px_x, bus.px_y);
        end
        checks++; if (bus.drop_count !== 16'd2) begin errors++; $display("FAIL clip_drops got %0d exp 2", bus.drop_count); end
    endtask

    // Scanner sweeps the last rows (476..480) over x 0..640, raising clr_done with the final sample.
    task automatic test_full_clear();
        int plots = 0, plot_bad = 0, coord_bad = 0, color_bad = 0, busy_bad = 0;
        int in_range_cnt, sample_cnt, extra_hi;
        do_reset();
        bus.clr_en = 1'b1; bus.clr_x = '0; bus.clr_y = 9'd476;
        tick();
        for (int y = 476; y <= 480; y++) begin
            for (int x = 0; x <= 640; x++) begin
                bus.clr_x = 10'(x); bus.clr_y = 9'(y);
                bus.clr_done = (x == 640) && (y == 480);
                if (bus.busy_clear !== 1'b1) busy_bad++;
                tick();
                if (bus.plot === 1'b1) plots++;
                if (bus.plot !== on_screen(x, y)) plot_bad++;
                if (bus.plot === 1'b1 && (bus.px_x !== 10'(x) || bus.px_y !== 9'(y))) coord_bad++;
                if (bus.plot === 1'b1 && bus.px_color !== 1'b0) color_bad++;
            end
        end
        in_range_cnt = 4 * 640;
        sample_cnt   = 5 * 641;
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL clear_busy low_cycles %0d exp 0", busy_bad); end
        checks++; if (plots != in_range_cnt) begin errors++; $display("FAIL clear_plots got %0d exp %0d", plots, in_range_cnt); end
        checks++; if (plot_bad != 0) begin errors++; $display("FAIL clear_plot_pattern bad %0d exp 0", plot_bad); end
        checks++; if (coord_bad != 0) begin errors++; $display("FAIL clear_coords bad %0d exp 0", coord_bad); end
        checks++; if (color_bad != 0) begin errors++; $display("FAIL clear_color bad %0d exp 0", color_bad); end
        checks++; if (bus.drop_count !== 16'(sample_cnt - in_range_cnt)) begin
            errors++; $display("FAIL clear_drops got %0d exp %0d", bus.drop_count, sample_cnt - in_range_cnt);
        end
        checks++; if (bus.frame_cleared !== 1'b1 || bus.busy_clear !== 1'b0) begin
            errors++; $display("FAIL clear_done_pulse got frame=%0h busy=%0h exp frame=1 busy=0", bus.frame_cleared, bus.busy_clear);
        end
        tick();
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL clear_done_ready got %0h exp 0", obs_ready); end
        checks++; if (bus.frame_cleared !== 1'b0) begin errors++; $display("FAIL clear_pulse_width got %0h exp 0", bus.frame_cleared); end
        extra_hi = 0;
        repeat (4) begin
            tick();
            if (bus.busy_clear !== 1'b0 || bus.frame_cleared !== 1'b0 || obs_ready !== 1'b1) extra_hi++;
        end
        checks++; if (extra_hi != 0) begin errors++; $display("FAIL clear_no_restart bad_cycles %0d exp 0", extra_hi); end
        drive_idle();
    endtask

    task automatic test_collision();
        int ready_hi = 0;
        do_reset();
        bus.clr_en = 1'b1; bus.clr_done = 1'b0; bus.clr_x = 10'd10; bus.clr_y = 9'd0;
        bus.drw_valid = 1'b1; bus.drw_x = 10'd3; bus.drw_y = 9'd4; bus.drw_color = 1'b1;
        tick();
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL coll_ready got %0h exp 0", obs_ready); end
        checks++; if (bus.busy_clear !== 1'b1) begin errors++; $display("FAIL coll_busy got %0h exp 1", bus.busy_clear); end
        for (int i = 0; i < 3; i++) begin
            bus.clr_x = 10'(10 + i);
            tick();
            if (obs_ready !== 1'b0) ready_hi++;
        end
        bus.clr_x = 10'd13; bus.clr_done = 1'b1;
        tick();
        if (obs_ready !== 1'b0) ready_hi++;
        checks++; if (bus.frame_cleared !== 1'b1) begin errors++; $display("FAIL coll_frame got %0h exp 1", bus.frame_cleared); end
        tick();
        if (obs_ready !== 1'b0) ready_hi++;
        checks++; if (ready_hi != 0) begin errors++; $display("FAIL coll_stall ready_cycles %0d exp 0", ready_hi); end
        checks++; if (bus.plot !== 1'b0) begin errors++; $display("FAIL coll_no_early_plot got %0h exp 0", bus.plot); end
        tick();
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL coll_accept_ready got %0h exp 1", obs_ready); end
        checks++; if (bus.plot !== 1'b1 || bus.px_x !== 10'd3 || bus.px_y !== 9'd4 || bus.px_color !== 1'b1) begin
            errors++; $display("FAIL coll_accept got plot=%0h (%0d,%0d,%0d) exp plot=1 (3,4,1)", bus.plot, bus.px_x, bus.px_y, bus.px_color);
        end
        drive_idle();
    endtask

    task automatic test_abort();
        do_reset();
        bus.clr_en = 1'b1; bus.clr_x = 10'd95; bus.clr_y = 9'd3;
        tick();
        for (int x = 95; x < 100; x++) begin
            bus.clr_x = 10'(x);
            tick();
        end
        bus.clr_x = 10'd100; bus.clr_en = 1'b0;
        tick();
        checks++; if (bus.busy_clear !== 1'b0 || bus.frame_cleared !== 1'b0) begin
            errors++; $display("FAIL abort_state got busy=%0h frame=%0h exp 0 0", bus.busy_clear, bus.frame_cleared);
        end
        checks++; if (bus.plot !== 1'b1 || bus.px_x !== 10'd100 || bus.px_y !== 9'd3) begin
            errors++; $display("FAIL abort_last_sample got plot=%0h (%0d,%0d) exp plot=1 (100,3)", bus.plot, bus.px_x, bus.px_y);
        end
        #1;
        checks++; if (bus.drw_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %0h exp 1", bus.drw_ready); end
        tick();
        checks++; if (bus.frame_cleared !== 1'b0) begin errors++; $display("FAIL abort_no_frame got %0h exp 0", bus.frame_cleared); end
        bus.clr_en = 1'b1; bus.clr_done = 1'b0;
        tick();
        checks++; if (bus.busy_clear !== 1'b1) begin errors++; $display("FAIL abort_restart got %0h exp 1", bus.busy_clear); end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        bus.clr_en = 1'b1; bus.clr_x = 10'd640; bus.clr_y = 9'd2;
        tick();
        tick();
        bus.clr_x = 10'd7;
        tick();
        checks++; if (bus.drop_count !== 16'd1 || bus.px_x !== 10'd7) begin
            errors++; $display("FAIL rmc_setup got drop=%0d x=%0d exp drop=1 x=7", bus.drop_count, bus.px_x);
        end
        bus.clr_x = 10'd5; bus.clr_y = 9'd5; reset = 1'b1;
        tick();
        reset = 1'b0; bus.clr_en = 1'b0;
        checks++; if (bus.plot !== 1'b0 || bus.busy_clear !== 1'b0 || bus.frame_cleared !== 1'b0) begin
            errors++; $display("FAIL rmc_flags got plot=%0h busy=%0h frame=%0h exp 0 0 0", bus.plot, bus.busy_clear, bus.frame_cleared);
        end
        checks++; if (bus.px_x !== 10'd0 || bus.px_y !== 9'd0 || bus.px_color !== 1'b0 || bus.drop_count !== 16'd0) begin
            errors++; $display("FAIL rmc_data got (%0d,%0d,%0d) drop=%0d exp (0,0,0) drop=0", bus.px_x, bus.px_y, bus.px_color, bus.drop_count);
        end
        tick();
        checks++; if (bus.frame_cleared !== 1'b0) begin errors++; $display("FAIL rmc_no_frame got %0h exp 0", bus.frame_cleared); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(0, 99) == 0);
            bus.clr_en    = ($urandom_range(0, 9) < 8);
            bus.clr_done  = ($urandom_range(0, 19) == 0);
            bus.clr_x     = $urandom_range(0, 1) ? 10'($urandom_range(630, 650)) : 10'($urandom_range(0, 1023));
            bus.clr_y     = $urandom_range(0, 1) ? 9'($urandom_range(470, 490)) : 9'($urandom_range(0, 511));
            bus.drw_valid = $urandom_range(0, 1);
            bus.drw_x     = $urandom_range(0, 1) ? 10'($urandom_range(630, 650)) : 10'($urandom_range(0, 1023));
            bus.drw_y     = $urandom_range(0, 1) ? 9'($urandom_range(470, 490)) : 9'($urandom_range(0, 511));
            bus.drw_color = 1'($urandom_range(0, 1));
            tick();
            checks++; if (obs_ready !== m_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %0h exp %0h", n, obs_ready, m_ready); end
            checks++; if (bus.plot !== m_plot) begin errors++; $display("FAIL rnd_plot[%0d] got %0h exp %0h", n, bus.plot, m_plot); end
            checks++; if (bus.px_x !== 10'(m_x) || bus.px_y !== 9'(m_y) || bus.px_color !== 1'(m_c)) begin
                errors++; $display("FAIL rnd_pixel[%0d] got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", n, bus.px_x, bus.px_y, bus.px_color, m_x, m_y, m_c);
            end
            checks++; if (bus.busy_clear !== m_busy || bus.frame_cleared !== m_frame) begin
                errors++; $display("FAIL rnd_status[%0d] got busy=%0h frame=%0h exp busy=%0h frame=%0h", n, bus.busy_clear, bus.frame_cleared, m_busy, m_frame);
            end
            checks++; if (bus.drop_count !== exp_drops()) begin errors++; $display("FAIL rnd_drops[%0d] got %0d exp %0d", n, bus.drop_count, exp_drops()); end
        end
        reset = 1'b0;
        drive_idle();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.drw_valid = 1'b1; bus.drw_x = 10'd1000; bus.drw_y = 9'd0;
        repeat (65534) tick();
        checks++; if (bus.drop_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %0h exp fffe", bus.drop_count); end
        tick();
        checks++; if (bus.drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %0h exp ffff", bus.drop_count); end
        repeat (5) tick();
        checks++; if (bus.drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %0h exp ffff", bus.drop_count); end
        checks++; if (bus.plot !== 1'b0) begin errors++; $display("FAIL sat_plot got %0h exp 0", bus.plot); end
        drive_idle();
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_draw_in_range();
        test_clipping();
        test_full_clear();
        test_collision();
        test_abort();
        test_reset_mid_clear();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_arbiter.md
# pixel_arbiter

Downstream of the screen-clear scanner, in front of the VGA framebuffer write port. Each cycle it selects one pixel source: either the clear scanner's coordinate sweep or a valid/ready pixel-draw request from the game drawing logic. It clips out-of-range coordinates, drives a registered framebuffer write (`plot`, coordinates, colour), and pulses `frame_cleared` once per completed clear.

## Interface
- `WIDTH`, 640: visible columns; valid x is 0..WIDTH-1
- `HEIGHT`, 480: visible rows; valid y is 0..HEIGHT-1
- `COLOR_W`, 1: pixel colour width
- `CLEAR_COLOR`, 0: colour written during a clear
- `clk` in 1: single clock for all logic
- `reset` in 1: synchronous, active-high
- `clr_en` in 1: clear scanner enabled (its start/“waited” input)
- `clr_x` in 10: scanner x coordinate
- `clr_y` in 9: scanner y coordinate
- `clr_done` in 1: scanner finished (its `cleared`)
- `drw_valid` in 1: draw request valid
- `drw_x` in 10: draw request x
- `drw_y` in 9: draw request y
- `drw_color` in COLOR_W: draw request colour
- `drw_ready` out 1: draw request accepted this cycle when high with `drw_valid`
- `plot` out 1: framebuffer write strobe
- `px_x` out 10: write x
- `px_y` out 9: write y
- `px_color` out COLOR_W: write colour
- `busy_clear` out 1: high while in CLEAR
- `frame_cleared` out 1: one-cycle pulse when a clear completes
- `drop_count` out 16: clipped-coordinate count; saturates at 16'hFFFF

## Operation
- States: IDLE, CLEAR, DONE.
- `start = clr_en & ~clr_done`.
- **IDLE → CLEAR** when `start`. Otherwise IDLE holds.
- **CLEAR → DONE** when `clr_done=1`.
- **CLEAR → IDLE** when `clr_en=0`. This is an abort; `frame_cleared` does not pulse.
- **DONE → IDLE** unconditionally after one cycle. `clr_done` stays high while `clr_en` is high, so the block does not re-enter CLEAR until the scanner restarts.
- **Drawing:** `drw_ready = (ps==IDLE) & ~start`, combinational. A clear therefore wins over a simultaneous draw request. A transfer happens when `drw_valid & drw_ready`.
- **CLEAR sampling:** every CLEAR cycle samples `clr_x`/`clr_y` with `CLEAR_COLOR`. This includes the cycle in which `clr_done` is first seen high; the sample is still taken and clipped normally. Scanner coordinates are ignored in IDLE and DONE.
- **Clipping:**
  - A sample is in range iff `x < WIDTH` and `y < HEIGHT`, compared at full port width.
  - In range: `plot=1` next cycle.
  - Out of range (e.g. the scanner's x=640 or y=480 samples): `plot=0` and `drop_count` increments.
  - Clipping applies identically to clear and draw sources.
- **drop_count:** never wraps; it is cleared only by `reset`.
- **Idle outputs:** when no sample is taken, `plot=0`. `px_x`/`px_y`/`px_color` hold their last value.

## Timing
- Reset values: `ps=IDLE`, `plot=0`, `px_x=0`, `px_y=0`, `px_color=0`, `busy_clear=0`, `frame_cleared=0`, `drop_count=0`. `drw_ready` follows the IDLE equation, so it is 1 when `start=0`.
- Latency: exactly 1 cycle from sample (draw handshake or CLEAR-cycle coordinate) to `plot`/`px_*`. Throughput is 1 pixel per cycle.
- `busy_clear` is registered and equals `ps==CLEAR`. It rises the cycle after `start` is seen in IDLE.
- `frame_cleared` is high during the single DONE cycle only.
- `reset` mid-CLEAR returns to IDLE next edge, suppresses any pending `plot` (`plot=0` after reset), and emits no `frame_cleared`.
- `clr_en` and `clr_done` both high while in IDLE does not start a clear.
- Draw requests are stalled (`drw_ready=0`) for the whole of CLEAR and DONE. Requesters must hold `drw_*` stable until accepted.

## Test plan
- **Draw in range:** reset, then `drw_valid=1`, (x,y,c)=(5,7,1) for 1 cycle. Expect `drw_ready=1`; next cycle `plot=1`, `px_x=5`, `px_y=7`, `px_color=1`; the cycle after, `plot=0`.
- **Clipping:** draw (640,10) then (639,479) then (0,480). Expect only (639,479) to plot; `drop_count=2`.
- **Full clear:** a scanner model sweeps x 0..640, y 0..480, then raises `clr_done`.
  - Expect 307200 plots, all with colour 0.
  - Expect `drop_count=641+480=1121`, `busy_clear` high throughout, one `frame_cleared` pulse, then IDLE with no restart while `clr_done=1`.
- **Clear/draw collision:** `start` and `drw_valid` asserted in the same cycle. Expect `drw_ready=0`, CLEAR entered, and the draw accepted only in the cycle after the DONE → IDLE transition (IDLE again).
- **Abort:** drop `clr_en` at (100,3). Expect return to IDLE, no `frame_cleared`, `drw_ready=1`; raising `clr_en` again with `clr_done=0` restarts the clear.
- **Reset and saturation:** assert `reset` mid-clear. Expect all outputs at reset values next cycle. Separately, force 65540 clipped draws and expect `drop_count=16'hFFFF`.
